// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU pipeline stage registers.
//   - ALU opcode used as the "no operation" encoding
//   - bit positions of the fields in the 11-bit control word
//   - NOP_CTRL_DEFAULT: the control word presented on a bubble
//   - stage state encoding; the state value doubles as the occupancy count
package cpu_pkg;

    localparam logic [4:0] OP_NOP = 5'b11111;

    // Control word layout (MSB to LSB):
    // RegWrite | ResultSrc | MemWrite | Jump | Branch | ALUSrc | ALUControl[4:0]
    localparam int CTRL_BIT_REGWRITE  = 10;
    localparam int CTRL_BIT_RESULTSRC = 9;
    localparam int CTRL_BIT_MEMWRITE  = 8;
    localparam int CTRL_BIT_JUMP      = 7;
    localparam int CTRL_BIT_BRANCH    = 6;
    localparam int CTRL_BIT_ALUSRC    = 5;
    localparam int CTRL_ALU_MSB       = 4;
    localparam int CTRL_ALU_LSB       = 0;

    localparam int CTRL_W_DEFAULT = 11;

    // All strobes low, ALU opcode set to OP_NOP.
    localparam logic [CTRL_W_DEFAULT-1:0] NOP_CTRL_DEFAULT = {6'b000000, OP_NOP};

    // Stage state; the numeric value equals the number of held entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: width-parametrised enable-load register holding one stage entry
// ({ctrl, data}).
// Ports:
//   clk    rising-edge clock
//   reset  active-low synchronous reset, loads RST_VAL
//   load   capture d on this edge
//   d      next value
//   q      held value
module pipe_slot #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline stage register between two CPU stages
// with a valid/ready handshake on both sides and a two-entry skid buffer.
// Ports:
//   clk, reset           rising-edge clock, active-low synchronous reset
//   flush                synchronous squash of all held entries
//   in_valid/in_ready    upstream handshake
//   in_ctrl/in_data      upstream entry
//   out_valid/out_ready  downstream handshake
//   out_ctrl/out_data    head entry; out_ctrl is NOP_CTRL whenever empty
//   occupancy            number of held entries (0..2)
module pipe_stage_elastic
    import cpu_pkg::*;
#(
    parameter int                CTRL_W   = 11,
    parameter int                DATA_W   = 207,
    parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(NOP_CTRL_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int SLOT_W = CTRL_W + DATA_W;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              accept;
    logic              consume;
    logic              head_ld;
    logic [SLOT_W-1:0] head_d;
    logic [SLOT_W-1:0] head_q;
    logic              skid_ld;
    logic [SLOT_W-1:0] skid_q;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;

    assign head_ctrl = head_q[SLOT_W-1:DATA_W];
    assign head_data = head_q[DATA_W-1:0];

    // Both handshake outputs come straight from the state register, so
    // out_ready never reaches in_ready combinationally.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;
    assign out_ctrl  = head_ctrl;
    assign out_data  = head_data;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        head_ld   = 1'b0;
        head_d    = {in_ctrl, in_data};
        skid_ld   = 1'b0;
        if (flush) begin
            // Anything accepted this cycle is squashed along with the held
            // entries; the skid contents are simply never read again.
            state_nxt = ST_EMPTY;
            head_ld   = 1'b1;
            head_d    = {NOP_CTRL, head_data};
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        head_ld   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        head_ld = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                        skid_ld   = 1'b1;
                    end else if (consume) begin
                        // Going empty: squash control, keep the payload.
                        state_nxt = ST_EMPTY;
                        head_ld   = 1'b1;
                        head_d    = {NOP_CTRL, head_data};
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_nxt = ST_ONE;
                        head_ld   = 1'b1;
                        head_d    = skid_q;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    head_ld   = 1'b1;
                    head_d    = {NOP_CTRL, head_data};
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    pipe_slot #(
        .W       (SLOT_W),
        .RST_VAL ({NOP_CTRL, {DATA_W{1'b0}}})
    ) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (head_ld),
        .d     (head_d),
        .q     (head_q)
    );

    pipe_slot #(
        .W       (SLOT_W),
        .RST_VAL ({SLOT_W{1'b0}})
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_ld),
        .d     ({in_ctrl, in_data}),
        .q     (skid_q)
    );

endmodule
